btn_event_arbiter: RTL and testbench
====================================

# btn_event_arbiter

Converts the debounced button levels of the OLED demo into a single stream of discrete press and auto-repeat events, and shares one downstream consumer (the OLED command sequencer) among all buttons. Each button has its own hold/repeat timer. Pending events are held per button and granted round-robin over a valid/ready handshake. The block sits between the per-button debouncer outputs and the display control logic.

## Interface
- NUM_BTN, 4, number of buttons (≥2)
- ID_WIDTH, 2, width of evt_id; ≥ ceil(log2(NUM_BTN))
- DELAY_MAX, 49_999_999, cycles from press event to first repeat event, minus 1
- PERIOD_MAX, 9_999_999, cycles between repeat events, minus 1
- CNT_WIDTH, 26, timer width; must hold max(DELAY_MAX, PERIOD_MAX)
- REPEAT_EN, 1, 0 disables all repeat events (timers held in IDLE)

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  synchronous, active-high reset
- btn_lvl  in  NUM_BTN  debounced button levels, already synchronous to clk
- evt_valid  out  1  event available
- evt_ready  in  1  consumer accepts event
- evt_id  out  ID_WIDTH  button index of the event
- evt_repeat  out  1  0 = press event, 1 = auto-repeat event
- pending  out  NUM_BTN  per-button pending-event flags, registered
- overrun  out  1  one-cycle pulse: an event arrived for a button already pending

## Operation
- Edge detect: prev[i] resets to 0. A press is detected at a clock edge where btn_lvl[i]=1 and prev[i]=0. A button held through reset therefore yields one press event after reset. prev <= btn_lvl every cycle.
- Per-button timer FSM, states IDLE, DELAY, REPEAT; counter resets to 0.
  - IDLE -> DELAY on a press; counter cleared.
  - DELAY: counter increments each cycle. At count==DELAY_MAX: raise a repeat event, clear the counter, go to REPEAT.
  - REPEAT: at count==PERIOD_MAX: raise a repeat event and clear the counter.
  - Any state -> IDLE, counter cleared, when btn_lvl[i]=0. This takes precedence over expiry in the same cycle.
  - REPEAT_EN=0: the FSM never leaves IDLE.
- Pending store: each button has pending[i] and kind[i].
  - A raised event sets pending[i]. kind[i] <= 1 for repeat, 0 for press.
  - If pending[i] is already 1 and is not being granted this cycle, the event merges: pending stays 1, kind[i] <= kind[i] & new_kind (press dominates), and overrun pulses.
- Output slot: one registered entry (evt_valid, evt_id, evt_repeat).
  - The slot is free when evt_valid=0, or when evt_valid=1 and evt_ready=1.
  - When the slot is free and any pending bit is set, grant the first set bit searching from rr_ptr+1 upward with wrap. Load its id and kind, clear its pending bit, set rr_ptr <= granted id.
  - When the slot is free and nothing is pending, evt_valid <= 0.
- Simultaneous grant and new event on the same button: the grant takes the old event, pending stays 1 with the new kind, and overrun does not pulse.
- Handshake: evt_id and evt_repeat are stable while evt_valid=1 and evt_ready=0. A transfer occurs on any edge where both are high. evt_ready is ignored while evt_valid=0.

## Timing
- Reset values: evt_valid=0, evt_id=0, evt_repeat=0, pending=0, overrun=0. Also rr_ptr=NUM_BTN-1 (button 0 has first priority), all FSMs IDLE, all counters 0, prev=0.
- Reset mid-operation discards the slot contents and all pending events. No event is emitted for activity before reset, except a button still high, which re-detects as a press.
- Press latency: press detected at edge n -> pending[i]=1 after edge n. With the slot free, evt_valid=1 after edge n+1.
- First repeat is raised DELAY_MAX+1 cycles after the press edge. Subsequent repeats are every PERIOD_MAX+1 cycles.
- Throughput is one event per cycle with evt_ready held high.
- overrun is registered and asserted for the cycle after the merging edge.

## Structure
- Shared package: timer state encoding (IDLE/DELAY/REPEAT), default timing constants for the 100 MHz demo clock, and the event kind encoding (PRESS=0, REPEAT=1).
- Sub-module btn_repeat_timer, one instance per button (generate loop). It contains prev, the FSM and the counter, and outputs an event strobe and kind.
- The top level holds the pending store, the round-robin arbiter and the output slot.

## Test plan
- Reset, then btn_lvl=4'b0010 pulsed for 3 cycles with evt_ready=1 -> exactly one event, id=1, repeat=0, evt_valid high 2 cycles after the press edge. No repeats with DELAY_MAX=7 (a 3-cycle hold is shorter than the first-repeat delay).
- DELAY_MAX=7, PERIOD_MAX=3, button 2 held for 30 cycles with ready=1 -> press, then repeats at +8, +12, +16, …. Releasing stops the repeats immediately, including on a cycle where the counter would have expired.
- Buttons 0,1,3 pressed on the same edge with evt_ready=0 for 10 cycles, then ready=1 -> ids 0,1,3 emitted on consecutive cycles; id 0 held stable during the stall.
- Continued contention after granting id 3 -> next search starts at 0 (wrap). Button 3 re-pressed while 1 and 2 are pending -> order 1, 2, 3.
- Button 0 pending with ready=0 and a repeat raised for it -> overrun=1 for one cycle; one event still delivered, with repeat=0.
- rst asserted while evt_valid=1 and pending=4'b0110 -> next cycle all outputs 0. Held button 2 produces one press event after rst deasserts.

Source files
------------

// File: rtl/btn_event_arbiter_pkg.sv
// Shared types and default constants for the button event arbiter.
// The timing defaults suit the 100 MHz OLED demo clock.
package btn_event_arbiter_pkg;

    typedef enum logic [1:0] {
        TMR_IDLE   = 2'd0,
        TMR_DELAY  = 2'd1,
        TMR_REPEAT = 2'd2
    } tmr_state_t;

    typedef enum logic {
        KIND_PRESS  = 1'b0,
        KIND_REPEAT = 1'b1
    } evt_kind_t;

    localparam int DEF_NUM_BTN    = 4;
    localparam int DEF_ID_WIDTH   = 2;
    localparam int DEF_DELAY_MAX  = 49_999_999;  // 0.5 s to first repeat
    localparam int DEF_PERIOD_MAX = 9_999_999;   // 0.1 s between repeats
    localparam int DEF_CNT_WIDTH  = 26;

    // Index reached by stepping 'off' places past 'base' in a ring of 'n'.
    function automatic int ring_step(input int base, input int off, input int n);
        int s;
        s = base + off;
        if (s >= n) s = s - n;
        return s;
    endfunction

endpackage

// File: rtl/btn_event_arbiter_if.sv
// Valid/ready event channel between the arbiter and the OLED command sequencer.
interface btn_event_arbiter_if #(
    parameter int ID_WIDTH = 2
) ();
    logic                evt_valid;
    logic                evt_ready;
    logic [ID_WIDTH-1:0] evt_id;
    logic                evt_repeat;

    modport master (
        output evt_valid,
        output evt_id,
        output evt_repeat,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_id,
        input  evt_repeat,
        output evt_ready
    );
endinterface

// File: rtl/btn_event_arbiter_timer.sv
// Per-button edge detector and hold/repeat timer producing a one-cycle
// event strobe with its kind, combinationally from the current level.
module btn_repeat_timer
    import btn_event_arbiter_pkg::*;
#(
    parameter int DELAY_MAX  = DEF_DELAY_MAX,
    parameter int PERIOD_MAX = DEF_PERIOD_MAX,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int REPEAT_EN  = 1
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_lvl,
    output logic      o_evt,
    output evt_kind_t o_kind
);

    localparam logic [CNT_WIDTH-1:0] DELAY_LAST  = CNT_WIDTH'(DELAY_MAX);
    localparam logic [CNT_WIDTH-1:0] PERIOD_LAST = CNT_WIDTH'(PERIOD_MAX);

    logic                 r_prev;
    tmr_state_t           r_state;
    logic [CNT_WIDTH-1:0] r_cnt;

    logic w_press;
    logic w_delay_exp;
    logic w_period_exp;
    logic w_repeat;

    assign w_press      = i_lvl & ~r_prev;
    assign w_delay_exp  = (r_state == TMR_DELAY)  && (r_cnt == DELAY_LAST);
    assign w_period_exp = (r_state == TMR_REPEAT) && (r_cnt == PERIOD_LAST);
    // A release on an expiry cycle suppresses the repeat.
    assign w_repeat     = i_lvl & (w_delay_exp | w_period_exp);

    assign o_evt  = w_press | w_repeat;
    assign o_kind = w_repeat ? KIND_REPEAT : KIND_PRESS;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev  <= 1'b0;
            r_state <= TMR_IDLE;
            r_cnt   <= '0;
        end else begin
            r_prev <= i_lvl;
            if (!i_lvl) begin
                r_state <= TMR_IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    TMR_IDLE: begin
                        if (w_press && (REPEAT_EN != 0)) begin
                            r_state <= TMR_DELAY;
                            r_cnt   <= '0;
                        end
                    end
                    TMR_DELAY: begin
                        if (w_delay_exp) begin
                            r_state <= TMR_REPEAT;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    TMR_REPEAT: begin
                        if (w_period_exp) r_cnt <= '0;
                        else              r_cnt <= r_cnt + 1'b1;
                    end
                    default: begin
                        r_state <= TMR_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/btn_event_arbiter.sv
// Top level: per-button timers, pending-event store, round-robin arbiter
// and the single registered output slot of the event channel.
module btn_event_arbiter
    import btn_event_arbiter_pkg::*;
#(
    parameter int NUM_BTN    = DEF_NUM_BTN,
    parameter int ID_WIDTH   = DEF_ID_WIDTH,
    parameter int DELAY_MAX  = DEF_DELAY_MAX,
    parameter int PERIOD_MAX = DEF_PERIOD_MAX,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int REPEAT_EN  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTN-1:0]  btn_lvl,
    btn_event_arbiter_if.master evt,
    output logic [NUM_BTN-1:0]  pending,
    output logic                overrun
);

    logic [NUM_BTN-1:0]  w_evt;
    logic [NUM_BTN-1:0]  w_kind;

    logic [NUM_BTN-1:0]  r_pend;
    logic [NUM_BTN-1:0]  r_kind;
    logic                r_overrun;
    logic                r_valid;
    logic [ID_WIDTH-1:0] r_id;
    logic                r_repeat;
    logic [ID_WIDTH-1:0] r_rr;

    logic                w_slot_free;
    logic                w_found;
    logic [ID_WIDTH-1:0] w_gnt_id;
    logic [NUM_BTN-1:0]  w_sel_oh;
    logic [NUM_BTN-1:0]  w_gnt;
    logic                w_sel_kind;

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        evt_kind_t w_kind_e;

        btn_repeat_timer #(
            .DELAY_MAX  (DELAY_MAX),
            .PERIOD_MAX (PERIOD_MAX),
            .CNT_WIDTH  (CNT_WIDTH),
            .REPEAT_EN  (REPEAT_EN)
        ) u_timer (
            .clk    (clk),
            .rst    (rst),
            .i_lvl  (btn_lvl[gi]),
            .o_evt  (w_evt[gi]),
            .o_kind (w_kind_e)
        );

        assign w_kind[gi] = w_kind_e;
    end

    assign w_slot_free = ~r_valid | evt.evt_ready;

    // Search starts one past the last grant, so every button gets a turn.
    // NOTE: outputs get defaults first so no path through the loop infers a latch.
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        w_sel_oh = '0;
        for (int k = 1; k <= NUM_BTN; k++) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (!w_found && r_pend[i] &&
                    (i == ring_step(int'(r_rr), k, NUM_BTN))) begin
                    w_found     = 1'b1;
                    w_gnt_id    = ID_WIDTH'(i);
                    w_sel_oh[i] = 1'b1;
                end
            end
        end
    end

    assign w_gnt      = w_sel_oh & {NUM_BTN{w_slot_free}};
    assign w_sel_kind = |(r_kind & w_sel_oh);

    // A new event on a pending, ungranted button merges; press dominates.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend    <= '0;
            r_kind    <= '0;
            r_overrun <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (w_evt[i]) begin
                    r_pend[i] <= 1'b1;
                    if (r_pend[i] && !w_gnt[i]) r_kind[i] <= r_kind[i] & w_kind[i];
                    else                        r_kind[i] <= w_kind[i];
                end else if (w_gnt[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
            r_overrun <= |(w_evt & r_pend & ~w_gnt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_id     <= '0;
            r_repeat <= 1'b0;
            r_rr     <= ID_WIDTH'(NUM_BTN - 1);
        end else if (w_slot_free) begin
            if (w_found) begin
                r_valid  <= 1'b1;
                r_id     <= w_gnt_id;
                r_repeat <= w_sel_kind;
                r_rr     <= w_gnt_id;
            end else begin
                r_valid  <= 1'b0;
            end
        end
    end

    assign evt.evt_valid  = r_valid;
    assign evt.evt_id     = r_id;
    assign evt.evt_repeat = r_repeat;
    assign pending        = r_pend;
    assign overrun        = r_overrun;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed and random checks of btn_event_arbiter against a timeline model
// that derives events from how long each button has been held.
module tb_btn_event_arbiter;

    localparam int NB   = 4;
    localparam int IDW  = 2;
    localparam int DMAX = 7;
    localparam int PMAX = 3;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn_lvl = '0;
    logic [NB-1:0] pending;
    logic          overrun;

    btn_event_arbiter_if #(.ID_WIDTH(IDW)) bus ();

    btn_event_arbiter #(
        .NUM_BTN    (NB),
        .ID_WIDTH   (IDW),
        .DELAY_MAX  (DMAX),
        .PERIOD_MAX (PMAX),
        .CNT_WIDTH  (CW),
        .REPEAT_EN  (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_lvl (btn_lvl),
        .evt     (bus),
        .pending (pending),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    // Reference state: held age per button (-1 = not held since a press).
    int m_age  [NB];
    bit m_prev [NB];
    bit m_pend [NB];
    bit m_kind [NB];
    bit m_valid, m_rep, m_ovr;
    int m_id, m_rr;

    int n_cmp = 0;
    int n_bad = 0;
    int n_ovr = 0;
    int xfer_id[$];
    int xfer_rep[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_age[i]  = -1;
            m_prev[i] = 1'b0;
            m_pend[i] = 1'b0;
            m_kind[i] = 1'b0;
        end
        m_valid = 1'b0;
        m_rep   = 1'b0;
        m_ovr   = 1'b0;
        m_id    = 0;
        m_rr    = NB - 1;
    endtask

    task automatic model_edge(input logic [NB-1:0] lvl, input bit rdy);
        bit ev[NB];
        bit kd[NB];
        bit free, found, gkind, ovr;
        int g, idx;
        free  = !m_valid || rdy;
        found = 1'b0;
        g     = 0;
        for (int k = 1; k <= NB; k++) begin
            idx = (m_rr + k) % NB;
            if (!found && m_pend[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
        gkind = m_kind[g];
        for (int i = 0; i < NB; i++) begin
            ev[i] = 1'b0;
            kd[i] = 1'b0;
            if (!lvl[i]) begin
                m_age[i] = -1;
            end else if (!m_prev[i]) begin
                m_age[i] = 0;
                ev[i]    = 1'b1;
            end else if (m_age[i] >= 0) begin
                m_age[i]++;
                if (m_age[i] > DMAX && ((m_age[i] - (DMAX + 1)) % (PMAX + 1)) == 0) begin
                    ev[i] = 1'b1;
                    kd[i] = 1'b1;
                end
            end
            m_prev[i] = lvl[i];
        end
        ovr = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (ev[i]) begin
                if (m_pend[i] && !(free && found && g == i)) begin
                    m_kind[i] = m_kind[i] & kd[i];
                    ovr       = 1'b1;
                end else begin
                    m_kind[i] = kd[i];
                end
                m_pend[i] = 1'b1;
            end else if (free && found && g == i) begin
                m_pend[i] = 1'b0;
            end
        end
        m_ovr = ovr;
        if (free) begin
            if (found) begin
                m_valid = 1'b1;
                m_id    = g;
                m_rep   = gkind;
                m_rr    = g;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic step(input logic [NB-1:0] lvl, input bit rdy, input bit r);
        logic [NB-1:0] mp;
        btn_lvl       = lvl;
        bus.evt_ready = rdy;
        rst           = r;
        if (!r && bus.evt_valid && rdy) begin
            xfer_id.push_back(int'(bus.evt_id));
            xfer_rep.push_back(int'(bus.evt_repeat));
        end
        if (r) model_reset();
        else   model_edge(lvl, rdy);
        @(posedge clk);
        #1;
        if (overrun) n_ovr++;
        for (int i = 0; i < NB; i++) mp[i] = m_pend[i];
        check("valid",   bus.evt_valid,  m_valid);
        check("id",      bus.evt_id,     m_id);
        check("repeat",  bus.evt_repeat, m_rep);
        check("pending", pending,        mp);
        check("overrun", overrun,        m_ovr);
    endtask

    task automatic check_xfers(input string tag, input int n, input int ids[4], input int reps[4]);
        check({tag, "_count"}, xfer_id.size(), n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_id%0d", tag, i),  (i < xfer_id.size())  ? xfer_id[i]  : -1, ids[i]);
            check($sformatf("%s_rep%0d", tag, i), (i < xfer_rep.size()) ? xfer_rep[i] : -1, reps[i]);
        end
    endtask

    task automatic clear_log();
        xfer_id.delete();
        xfer_rep.delete();
        n_ovr = 0;
    endtask

    initial begin
        int n_rep;
        logic [NB-1:0] lvl_r;
        bus.evt_ready = 1'b0;
        model_reset();

        // Reset state.
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        check("rst_valid",   bus.evt_valid, 0);
        check("rst_pending", pending,       0);

        // Short press on button 1: one press event, valid two edges in.
        clear_log();
        step(4'b0010, 1'b1, 1'b0);
        check("t1_pend_after_press", pending, 4'b0010);
        step(4'b0010, 1'b1, 1'b0);
        check("t1_valid_n1", bus.evt_valid, 1);
        check("t1_id_n1",    bus.evt_id,    1);
        step(4'b0010, 1'b1, 1'b0);
        repeat (8) step(4'b0000, 1'b1, 1'b0);
        check_xfers("t1", 1, '{1, 0, 0, 0}, '{0, 0, 0, 0});

        // Button 2 held: repeats at ages 8,12,...,28; release on age 32 expiry.
        clear_log();
        repeat (32) step(4'b0100, 1'b1, 1'b0);
        repeat (12) step(4'b0000, 1'b1, 1'b0);
        n_rep = 0;
        foreach (xfer_rep[i]) n_rep += xfer_rep[i];
        check("t2_total",   xfer_id.size(), 7);
        check("t2_repeats", n_rep,          6);
        check("t2_first",   (xfer_id.size() > 0) ? xfer_rep[0] : -1, 0);

        // Three simultaneous presses under a 10-cycle stall.
        step(4'b0000, 1'b0, 1'b1);
        clear_log();
        step(4'b1011, 1'b0, 1'b0);
        step(4'b1011, 1'b0, 1'b0);
        repeat (8) step(4'b0000, 1'b0, 1'b0);
        check("t3_stall_valid", bus.evt_valid, 1);
        check("t3_stall_id",    bus.evt_id,    0);
        repeat (6) step(4'b0000, 1'b1, 1'b0);
        check_xfers("t3", 3, '{0, 1, 3, 0}, '{0, 0, 0, 0});

        // Wrap after id 3, then a late press on 3 queues behind 1 and 2.
        clear_log();
        step(4'b0111, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        check("t4_wrap_id", bus.evt_id, 0);
        step(4'b1000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        repeat (6) step(4'b0000, 1'b1, 1'b0);
        check_xfers("t4", 4, '{0, 1, 2, 3}, '{0, 0, 0, 0});

        // Repeat merges into a pending press on button 0.
        clear_log();
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0001, 1'b0, 1'b0);
        repeat (8) step(4'b0001, 1'b0, 1'b0);
        repeat (2) step(4'b0000, 1'b0, 1'b0);
        check("t5_overrun_pulses", n_ovr, 1);
        repeat (5) step(4'b0000, 1'b1, 1'b0);
        check_xfers("t5", 2, '{1, 0, 0, 0}, '{0, 0, 0, 0});

        // Reset with a loaded slot and pending 0110, button 2 still held.
        clear_log();
        step(4'b1000, 1'b0, 1'b0);
        step(4'b0110, 1'b0, 1'b0);
        check("t6_pre_pending", pending,       4'b0110);
        check("t6_pre_valid",   bus.evt_valid, 1);
        step(4'b0100, 1'b1, 1'b1);
        check("t6_rst_valid",   bus.evt_valid,  0);
        check("t6_rst_id",      bus.evt_id,     0);
        check("t6_rst_pending", pending,        0);
        step(4'b0100, 1'b1, 1'b0);
        step(4'b0100, 1'b1, 1'b0);
        repeat (4) step(4'b0000, 1'b1, 1'b0);
        check_xfers("t6", 1, '{2, 0, 0, 0}, '{0, 0, 0, 0});

        // Random levels, ready and occasional reset against the model.
        lvl_r = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NB; i++) begin
                if ($urandom_range(0, 5) == 0) lvl_r[i] = ~lvl_r[i];
            end
            step(lvl_r, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
